player_physics: RTL and testbench

- Per-player motion integrator for the right-hand (computer) player, directly downstream of the AI controller.
- Consumes op_move_left / op_move_right / op_jump / op_smash and produces the registered position fed back to the AI as my_pos_x / my_pos_y.
- Updates once per frame_tick. Provides horizontal stepping with court clamping, a gravity jump, and a timed smash window with cooldown.

---
 rtl/pong_pkg.sv | 13 +
 rtl/player_smash_timer.sv | 67 ++++++
 rtl/player_physics.sv | 114 +++++++++++
 tb/tb_player_physics.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Court constants and state encodings shared by the AI, ball physics and player physics blocks.
package pong_pkg;

  localparam int unsigned NET_X    = 160;
  localparam int unsigned CENTER_X = 210;
  localparam int unsigned GROUND_Y = 210;
  localparam int unsigned X_MIN    = 170;
  localparam int unsigned X_MAX    = 310;

  typedef enum logic {Ground, Air} motion_state_t;
  typedef enum logic [1:0] {Idle, Active, Cooldown} smash_state_t;

endpackage

// File: rtl/player_smash_timer.sv
// Smash window FSM: a timed active window while airborne, followed by a cooldown.
module player_smash_timer
  import pong_pkg::*;
#(
  parameter int unsigned SMASH_TICKS    = 6,
  parameter int unsigned COOLDOWN_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic op_smash,
  input  logic in_air,
  input  logic landing,
  output logic smash_active
);

  localparam int unsigned MaxTicks = (SMASH_TICKS > COOLDOWN_TICKS) ? SMASH_TICKS : COOLDOWN_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  smash_state_t    state_q;
  logic [CntW-1:0] cnt_q;
  logic            active_q;

  // A count of 1 means this tick decrements the counter to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= Idle;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        Idle: begin
          if (op_smash && in_air) begin
            state_q  <= Active;
            cnt_q    <= CntW'(SMASH_TICKS);
            active_q <= 1'b1;
          end
        end
        Active: begin
          if (landing || cnt_q == CntW'(1)) begin
            state_q  <= Cooldown;
            cnt_q    <= CntW'(COOLDOWN_TICKS);
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        Cooldown: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= Idle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q  <= Idle;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign smash_active = active_q;

endmodule

// File: rtl/player_physics.sv
// Per-frame motion integrator for the computer player: clamped x stepping, gravity jump, smash.
module player_physics
  import pong_pkg::*;
#(
  parameter int unsigned X_START        = CENTER_X,
  parameter int unsigned MOVE_STEP      = 3,
  parameter int unsigned JUMP_V0        = 12,
  parameter int unsigned GRAVITY        = 1,
  parameter int unsigned SMASH_TICKS    = 6,
  parameter int unsigned COOLDOWN_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              op_move_left,
  input  logic              op_move_right,
  input  logic              op_jump,
  input  logic              op_smash,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic signed [7:0] vel_y,
  output logic              in_air,
  output logic              smash_active
);

  localparam logic signed [10:0] GroundYS = 11'(GROUND_Y);
  localparam logic [9:0]         LaunchY  = 10'(GROUND_Y - JUMP_V0);
  // Gravity is already applied on the launch tick, so the stored speed is one step slower.
  localparam logic signed [7:0]  LaunchV  = 8'(GRAVITY) - 8'(JUMP_V0);

  motion_state_t     state_q;
  logic [9:0]        pos_x_q, pos_y_q;
  logic signed [7:0] vel_y_q;

  logic [10:0]        x_sum;
  logic [9:0]         x_next;
  logic signed [10:0] y_sum;
  logic signed [8:0]  vel_sum;
  logic signed [7:0]  vel_next;
  logic               landing;

  always_comb begin
    x_sum = {1'b0, pos_x_q};
    if (op_move_left && !op_move_right) begin
      x_sum = x_sum - 11'(MOVE_STEP);
    end else if (op_move_right && !op_move_left) begin
      x_sum = x_sum + 11'(MOVE_STEP);
    end
    if (x_sum < 11'(X_MIN)) begin
      x_next = 10'(X_MIN);
    end else if (x_sum > 11'(X_MAX)) begin
      x_next = 10'(X_MAX);
    end else begin
      x_next = x_sum[9:0];
    end
  end

  always_comb begin
    y_sum    = $signed({1'b0, pos_y_q}) + $signed({{3{vel_y_q[7]}}, vel_y_q});
    vel_sum  = $signed({vel_y_q[7], vel_y_q}) + $signed(9'(GRAVITY));
    vel_next = (vel_sum > 9'sd127) ? 8'sd127 : vel_sum[7:0];
    landing  = frame_tick && (state_q == Air) && (y_sum >= GroundYS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Ground;
      pos_x_q <= 10'(X_START);
      pos_y_q <= 10'(GROUND_Y);
      vel_y_q <= '0;
    end else if (frame_tick) begin
      pos_x_q <= x_next;
      unique case (state_q)
        Ground: begin
          if (op_jump) begin
            state_q <= Air;
            pos_y_q <= LaunchY;
            vel_y_q <= LaunchV;
          end
        end
        Air: begin
          if (landing) begin
            state_q <= Ground;
            pos_y_q <= 10'(GROUND_Y);
            vel_y_q <= '0;
          end else begin
            pos_y_q <= y_sum[9:0];
            vel_y_q <= vel_next;
          end
        end
        default: state_q <= Ground;
      endcase
    end
  end

  player_smash_timer #(
    .SMASH_TICKS   (SMASH_TICKS),
    .COOLDOWN_TICKS(COOLDOWN_TICKS)
  ) u_smash_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .op_smash    (op_smash),
    .in_air      (in_air),
    .landing     (landing),
    .smash_active(smash_active)
  );

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign vel_y  = vel_y_q;
  assign in_air = (state_q == Air);

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: reset, x clamping, jump arc, auto re-jump, smash and async reset.
module tb_player_physics;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_tick = 1'b0;
  logic              op_move_left = 1'b0;
  logic              op_move_right = 1'b0;
  logic              op_jump = 1'b0;
  logic              op_smash = 1'b0;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic signed [7:0] vel_y;
  logic              in_air;
  logic              smash_active;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  player_physics dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .op_move_left (op_move_left),
    .op_move_right(op_move_right),
    .op_jump      (op_jump),
    .op_smash     (op_smash),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .vel_y        (vel_y),
    .in_air       (in_air),
    .smash_active (smash_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Called at a negedge; returns at the next negedge with that tick's outputs visible.
  task automatic tick(input logic l, input logic r, input logic j, input logic s);
    op_move_left  = l;
    op_move_right = r;
    op_jump       = j;
    op_smash      = s;
    frame_tick    = 1'b1;
    @(negedge clk);
    frame_tick    = 1'b0;
    op_move_left  = 1'b0;
    op_move_right = 1'b0;
    op_jump       = 1'b0;
    op_smash      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Closed-form jump arc: tick n after launch (n=1 is the launch tick).
  function automatic int arc_y(input int n);
    int m;
    if (n <= 12) return 210 - (12 * n - (n * (n - 1)) / 2);
    m = n - 13;
    return 132 + (m * (m + 1)) / 2;
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_x", pos_x, 210);
    check("rst_y", pos_y, 210);
    check("rst_vy", vel_y, 0);
    check("rst_air", in_air, 0);
    check("rst_smash", smash_active, 0);

    for (int n = 1; n <= 10; n++) begin
      tick(0, 0, 0, 0);
      check("idle_x", pos_x, 210);
      check("idle_y", pos_y, 210);
      check("idle_vy", vel_y, 0);
      check("idle_air", in_air, 0);
      check("idle_smash", smash_active, 0);
    end

    for (int k = 1; k <= 40; k++) begin
      tick(0, 1, 0, 0);
      check("right_x", pos_x, (210 + 3 * k > 310) ? 310 : 210 + 3 * k);
    end
    op_move_right = 1'b1;
    repeat (2) @(negedge clk);
    op_move_right = 1'b0;
    check("hold_no_tick_x", pos_x, 310);
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1, 0, 0);
      check("both_x", pos_x, 310);
    end

    do_reset();
    check("rst2_x", pos_x, 210);
    for (int k = 1; k <= 14; k++) begin
      tick(1, 0, 0, 0);
      check("left_x", pos_x, (210 - 3 * k < 170) ? 170 : 210 - 3 * k);
    end

    // Single jump pulse.
    do_reset();
    tick(0, 0, 1, 0);
    check("launch_y", pos_y, 198);
    check("launch_vy", vel_y, -11);
    check("launch_air", in_air, 1);
    for (int n = 2; n <= 24; n++) begin
      tick(0, 0, 0, 0);
      check("arc_y", pos_y, arc_y(n));
      check("arc_vy", vel_y, n - 12);
      check("arc_air", in_air, 1);
      if (n == 12) check("apex_y", pos_y, 132);
    end
    tick(0, 0, 0, 0);
    check("land_y", pos_y, 210);
    check("land_vy", vel_y, 0);
    check("land_air", in_air, 0);

    // Held jump: landing tick stays grounded, next tick re-launches.
    for (int n = 1; n <= 25; n++) tick(0, 0, 1, 0);
    check("held_land_air", in_air, 0);
    check("held_land_y", pos_y, 210);
    tick(0, 0, 1, 0);
    check("rejump_y", pos_y, 198);
    check("rejump_air", in_air, 1);

    // Smash window then cooldown.
    do_reset();
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    check("pre_smash", smash_active, 0);
    for (int n = 3; n <= 12; n++) begin
      tick(0, 0, 0, n == 3);
      check("smash_win", smash_active, (n <= 8) ? 1 : 0);
    end
    tick(0, 0, 0, 1);
    check("smash_cooldown_ignored", smash_active, 0);
    for (int n = 14; n <= 30; n++) begin
      tick(0, 0, 0, n >= 26);
      check("smash_after", smash_active, 0);
    end
    check("smash_ground_air", in_air, 0);

    // Landing while active cuts the window short.
    do_reset();
    tick(0, 0, 1, 0);
    for (int n = 2; n <= 21; n++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("late_smash_on", smash_active, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("late_smash_still", smash_active, 1);
    tick(0, 0, 0, 0);
    check("late_land_air", in_air, 0);
    check("late_land_smash", smash_active, 0);

    // Asynchronous reset mid-air with the smash window open.
    do_reset();
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("pre_rst_y", pos_y, 153);
    check("pre_rst_x", pos_x, 216);
    check("pre_rst_smash", smash_active, 1);
    #1 rst = 1'b1;
    #1;
    check("async_y", pos_y, 210);
    check("async_vy", vel_y, 0);
    check("async_x", pos_x, 210);
    check("async_air", in_air, 0);
    check("async_smash", smash_active, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
